// File: rtl/dsp_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dsp_ctrl_pkg
// Shared definitions for the DSP48A1-style slice sequencers.
//   OPM_FIRST / OPM_ACC : slice OPMODE words (X=M, Z=0 / X=M, Z=P)
//   mac_state_e         : sequencer states
//   n_taps_ok()         : legal frame length check (sum must fit 48 bits)
//   pipe_lat_ok()       : legal slice latency check
// ----------------------------------------------------------------------------
package dsp_ctrl_pkg;

    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        OUT
    } mac_state_e;

    function automatic bit n_taps_ok(input int unsigned n);
        return (n >= 2) && (n <= 4096);
    endfunction

    function automatic bit pipe_lat_ok(input int unsigned n);
        return n >= 1;
    endfunction

endpackage

// File: rtl/dsp_mac_seq_if.sv
// ----------------------------------------------------------------------------
// dsp_mac_seq_if
// Operand stream (s_*) and result stream (r_*) of the MAC sequencer.
//   s_valid/s_ready/s_a/s_b : unsigned 18-bit operand pairs
//   r_valid/r_ready/r_data  : 48-bit dot-product results
// Modports: master = producer of operands / consumer of results,
//           slave  = the sequencer.
// ----------------------------------------------------------------------------
interface dsp_mac_seq_if;

    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_a;
    logic [17:0] s_b;
    logic        r_valid;
    logic        r_ready;
    logic [47:0] r_data;

    modport master (
        output s_valid, s_a, s_b, r_ready,
        input  s_ready, r_valid, r_data
    );

    modport slave (
        input  s_valid, s_a, s_b, r_ready,
        output s_ready, r_valid, r_data
    );

endinterface

// File: rtl/dsp_tag_pipe.sv
// ----------------------------------------------------------------------------
// dsp_tag_pipe
// 1-bit delay line of DEPTH registers with synchronous active-high reset.
//   clk    : clock
//   rst    : synchronous reset, clears all stages
//   i_data : tag entering stage 0
//   o_data : tag leaving stage DEPTH-1 (DEPTH cycles later)
// ----------------------------------------------------------------------------
module dsp_tag_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_data,
    output logic o_data
);

    logic [DEPTH-1:0] r_stages;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (rst) begin
                r_stages <= '0;
            end else begin
                r_stages <= i_data;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk) begin
            if (rst) begin
                r_stages <= '0;
            end else begin
                r_stages <= {r_stages[DEPTH-2:0], i_data};
            end
        end
    end

    assign o_data = r_stages[DEPTH-1];

endmodule

// File: rtl/dsp_mac_seq.sv
// ----------------------------------------------------------------------------
// dsp_mac_seq
// Operand sequencer in front of a DSP48A1-style slice. Each frame of N_TAPS
// accepted operand pairs becomes one 48-bit dot product on the result port.
//   clk        : clock
//   rst        : synchronous active-high reset
//   bus        : operand/result streams (slave side)
//   dsp_a/b    : slice A/B operands (zero on non-accept cycles)
//   dsp_opmode : slice OPMODE (OPM_FIRST one cycle after a frame's first pair)
//   dsp_ce     : slice clock enables, low only during reset
//   dsp_rst    : slice resets, follows rst
//   dsp_p      : slice P result
// ----------------------------------------------------------------------------
module dsp_mac_seq
    import dsp_ctrl_pkg::*;
#(
    parameter int unsigned N_TAPS   = 8,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    dsp_mac_seq_if.slave  bus,
    output logic [17:0]   dsp_a,
    output logic [17:0]   dsp_b,
    output logic [7:0]    dsp_opmode,
    output logic          dsp_ce,
    output logic          dsp_rst,
    input  logic [47:0]   dsp_p
);

    if (!n_taps_ok(N_TAPS)) begin : g_bad_n_taps
        $error("dsp_mac_seq: N_TAPS must be within 2..4096");
    end
    if (!pipe_lat_ok(PIPE_LAT)) begin : g_bad_pipe_lat
        $error("dsp_mac_seq: PIPE_LAT must be at least 1");
    end

    localparam int unsigned TapW   = $clog2(N_TAPS);
    localparam int unsigned DrainW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    mac_state_e          r_state;
    mac_state_e          w_state_next;
    logic [TapW-1:0]     r_tap_cnt;
    logic [DrainW-1:0]   r_drain_cnt;
    logic                r_res_valid;
    logic [47:0]         r_res_data;

    logic                w_accept;
    logic                w_last_tap;
    logic                w_first;
    logic                w_tag_first;
    logic                w_drain_done;

    // Accepts are ignored while in reset even though s_ready reads high.
    assign w_accept     = bus.s_valid && (r_state == ACCUM) && !rst;
    assign w_last_tap   = w_accept && (r_tap_cnt == TapW'(N_TAPS - 1));
    assign w_first      = w_accept && (r_tap_cnt == '0);
    assign w_drain_done = (r_state == DRAIN) && (r_drain_cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ACCUM: if (w_last_tap) w_state_next = DRAIN;
            DRAIN: if (w_drain_done) w_state_next = OUT;
            OUT:   if (r_res_valid && bus.r_ready) w_state_next = ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    // Outputs
    always_comb begin
        bus.s_ready = (r_state == ACCUM) || rst;
        dsp_a       = w_accept ? bus.s_a : '0;
        dsp_b       = w_accept ? bus.s_b : '0;
        // The slice registers OPMODE, so the tag is applied one cycle late.
        dsp_opmode  = w_tag_first ? OPM_FIRST : OPM_ACC;
        dsp_ce      = !rst;
        dsp_rst     = rst;
        bus.r_valid = r_res_valid;
        bus.r_data  = r_res_data;
    end

    // Tap and drain counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tap_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_last_tap) begin
                r_tap_cnt   <= '0;
                r_drain_cnt <= DrainW'(PIPE_LAT - 1);
            end else if (w_accept) begin
                r_tap_cnt <= r_tap_cnt + TapW'(1);
            end
            if ((r_state == DRAIN) && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - DrainW'(1);
            end
        end
    end

    // Result register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (w_drain_done) begin
            r_res_valid <= 1'b1;
            r_res_data  <= dsp_p;
        end else if ((r_state == OUT) && r_res_valid && bus.r_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    dsp_tag_pipe #(
        .DEPTH (1)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_first),
        .o_data (w_tag_first)
    );

endmodule
